// File: rtl/maxpool_2x2_stream_pkg.sv
// Shared constants for the 2x2 max-pool stage that sits behind the 5x5 conv.
//   POOL_DATA_W : signed sample width, equal to the conv output width
//   CONV_OUT_W  : columns of the conv feature map (pool input)
//   CONV_OUT_H  : rows of the conv feature map (pool input)
//   POOL_OUT_W  : columns of the pooled map
//   POOL_OUT_H  : rows of the pooled map
package maxpool_2x2_stream_pkg;

  localparam int POOL_DATA_W = 33;
  localparam int CONV_OUT_W  = 24;
  localparam int CONV_OUT_H  = 24;
  localparam int POOL_OUT_W  = CONV_OUT_W / 2;
  localparam int POOL_OUT_H  = CONV_OUT_H / 2;

  // Width of a counter or address that must reach n-1; never narrower than 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/maxpool_2x2_stream_line_buf.sv
// Half-width line buffer: holds the horizontal pair maxima of one even row
// so they can be combined with the pair maxima of the following odd row.
// Synchronous write, asynchronous (combinational) read; no reset because the
// contents are always written before they are read within a row pair.
//   clk       : system clock
//   wr_en_i   : write wr_data_i to entry wr_addr_i on this edge
//   wr_addr_i : write entry index (pooled column)
//   wr_data_i : pair maximum to store
//   rd_addr_i : read entry index (pooled column)
//   rd_data_o : stored pair maximum at rd_addr_i
module pool_line_buf #(
  parameter int DEPTH  = 12,
  parameter int DATA_W = 33,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/maxpool_2x2_stream.sv
// 2x2 stride-2 max pooling over a raster-ordered feature map, with optional
// ReLU on the pooled result. Output uses the same valid/data format as the
// input so a following stage can consume it unchanged.
//
// Handshake: there is no back-pressure. A sample is accepted on every rising
// edge where in_valid=1; data_in is ignored otherwise and all state holds.
// out_valid is a one-cycle pulse with data_out valid in that cycle only;
// data_out is forced to 0 whenever out_valid=0.
//
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   in_valid   : data_in carries a sample this cycle
//   data_in    : signed conv sample, row-major raster order
//   out_valid  : pooled sample valid (one cycle after the accepting edge)
//   data_out   : signed pooled sample, 0 when out_valid=0
//   frame_done : pulses with the last pooled sample of a frame
module maxpool_2x2_stream
  import maxpool_2x2_stream_pkg::*;
#(
  parameter int DATA_W  = POOL_DATA_W,
  parameter int IMG_W   = CONV_OUT_W,
  parameter int IMG_H   = CONV_OUT_H,
  parameter bit RELU_EN = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] data_in,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] data_out,
  output logic                     frame_done
);

  localparam int CW       = cnt_w(IMG_W);
  localparam int RW       = cnt_w(IMG_H);
  localparam int LB_DEPTH = IMG_W / 2;
  localparam int AW       = cnt_w(LB_DEPTH);

  logic [CW-1:0]            col_cnt_q, col_cnt_d;
  logic [RW-1:0]            row_cnt_q, row_cnt_d;
  logic signed [DATA_W-1:0] h_max_q, h_max_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0] data_out_q, data_out_d;
  logic                     frame_done_q, frame_done_d;

  logic                     col_last, row_last, col_odd, row_odd;
  logic [CW-1:0]            col_half;
  logic [AW-1:0]            lb_addr;
  logic                     lb_wr_en;
  logic [DATA_W-1:0]        lb_rd_data;
  logic signed [DATA_W-1:0] lb_pair;
  logic signed [DATA_W-1:0] pair;
  logic signed [DATA_W-1:0] result;

  assign col_last = (col_cnt_q == CW'(IMG_W - 1));
  assign row_last = (row_cnt_q == RW'(IMG_H - 1));
  assign col_odd  = col_cnt_q[0];
  assign row_odd  = row_cnt_q[0];

  // Pooled column index selects the line-buffer entry for both write and read.
  assign col_half = col_cnt_q >> 1;
  assign lb_addr  = AW'(col_half);
  assign lb_wr_en = in_valid && col_odd && !row_odd;
  assign lb_pair  = $signed(lb_rd_data);

  pool_line_buf #(
    .DEPTH  (LB_DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_line_buf (
    .clk       (clk),
    .wr_en_i   (lb_wr_en),
    .wr_addr_i (lb_addr),
    .wr_data_i (pair),
    .rd_addr_i (lb_addr),
    .rd_data_o (lb_rd_data)
  );

  // Horizontal pair maximum (meaningful on odd columns) and 2x2 result
  // (meaningful on odd rows, odd columns).
  always_comb begin
    pair   = (data_in > h_max_q) ? data_in : h_max_q;
    result = (lb_pair > pair) ? lb_pair : pair;
    if (RELU_EN && result[DATA_W-1]) begin
      result = '0;
    end
  end

  always_comb begin
    col_cnt_d    = col_cnt_q;
    row_cnt_d    = row_cnt_q;
    h_max_d      = h_max_q;
    out_valid_d  = 1'b0;
    data_out_d   = '0;
    frame_done_d = 1'b0;
    if (in_valid) begin
      if (col_last) begin
        col_cnt_d = '0;
        row_cnt_d = row_last ? '0 : row_cnt_q + 1'b1;
      end else begin
        col_cnt_d = col_cnt_q + 1'b1;
      end
      if (!col_odd) begin
        h_max_d = data_in;
      end
      if (col_odd && row_odd) begin
        out_valid_d  = 1'b1;
        data_out_d   = result;
        frame_done_d = col_last && row_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt_q    <= '0;
      row_cnt_q    <= '0;
      h_max_q      <= '0;
      out_valid_q  <= 1'b0;
      data_out_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_cnt_q    <= col_cnt_d;
      row_cnt_q    <= row_cnt_d;
      h_max_q      <= h_max_d;
      out_valid_q  <= out_valid_d;
      data_out_q   <= data_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign data_out   = data_out_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// Bench for maxpool_2x2_stream. Two instances share one input stream: one
// without ReLU, one with ReLU. Expected pooled values are written from the
// closed-form description of each test frame, pushed when the odd-row/odd-col
// sample is driven, and popped by a monitor on the falling edge.
module tb_maxpool_2x2_stream;

  localparam int W  = 33;
  localparam int IW = 24;
  localparam int IH = 24;
  localparam int PW = IW / 2;

  localparam int K_RAMP = 0;
  localparam int K_NEG5 = 1;
  localparam int K_WIN  = 2;
  localparam int K_POS  = 3;

  typedef struct {
    logic signed [W-1:0] d0;
    logic signed [W-1:0] d1;
    logic                fd;
    longint              due;
  } exp_t;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc++;

  logic                in_valid = 1'b0;
  logic signed [W-1:0] data_in = '0;
  logic                ov0, ov1, fd0, fd1;
  logic signed [W-1:0] do0, do1;

  maxpool_2x2_stream #(.DATA_W(W), .IMG_W(IW), .IMG_H(IH), .RELU_EN(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data_in(data_in),
    .out_valid(ov0), .data_out(do0), .frame_done(fd0)
  );

  maxpool_2x2_stream #(.DATA_W(W), .IMG_W(IW), .IMG_H(IH), .RELU_EN(1'b1)) dut_relu (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data_in(data_in),
    .out_valid(ov1), .data_out(do1), .frame_done(fd1)
  );

  // Scoreboard
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   fd_exp = 0;
  int   fd_seen0 = 0;
  int   fd_seen1 = 0;
  int   n_out0 = 0;

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stimulus values for each test frame
  function automatic longint sample_val(input int kind, input int r, input int c,
                                        input longint off);
    longint v;
    case (kind)
      K_RAMP: v = longint'(r * IW + c) + off;
      K_NEG5: v = -5;
      K_WIN: begin
        if (r == 0 && c == 0)      v = -64'sd4294967296;
        else if (r == 0 && c == 1) v = 64'sd4294967295;
        else if (r == 1 && c == 0) v = -1;
        else if (r == 1 && c == 1) v = 0;
        else                       v = -1;
      end
      default: v = (r == 7 && c == 13) ? 1000 : -1;
    endcase
    return v;
  endfunction

  // Hand-derived pooled value at pooled position (pr, pc)
  function automatic longint exp_val(input int kind, input int pr, input int pc,
                                     input longint off, input bit relu);
    longint v;
    int     pidx;
    pidx = pr * PW + pc;
    case (kind)
      K_RAMP: v = longint'((2 * pr + 1) * IW + 2 * pc + 1) + off;
      K_NEG5: v = relu ? 0 : -5;
      K_WIN:  v = (pidx == 0) ? 64'sd4294967295 : (relu ? 0 : -1);
      default: v = (pidx == 42) ? 1000 : (relu ? 0 : -1);
    endcase
    return v;
  endfunction

  // Driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      data_in  = W'($urandom);
    end
  endtask

  task automatic send_frame(input int kind, input longint off, input bit gaps,
                            input int n_samples);
    longint v;
    exp_t   e;
    for (int r = 0; r < IH; r++) begin
      for (int c = 0; c < IW; c++) begin
        if (r * IW + c >= n_samples) return;
        if (gaps && $urandom_range(0, 7) == 0) idle(1);
        @(posedge clk);
        #1;
        v = sample_val(kind, r, c, off);
        in_valid = 1'b1;
        data_in  = v[W-1:0];
        if ((r % 2 == 1) && (c % 2 == 1)) begin
          v    = exp_val(kind, r / 2, c / 2, off, 1'b0);
          e.d0 = v[W-1:0];
          v    = exp_val(kind, r / 2, c / 2, off, 1'b1);
          e.d1 = v[W-1:0];
          e.fd = (r == IH - 1) && (c == IW - 1);
          e.due = cyc + 1;
          if (e.fd) fd_exp++;
          exp_q.push_back(e);
        end
      end
      if (gaps) idle(4);
    end
  endtask

  // Monitor: compares both instances on the falling edge
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      e = exp_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL late_output: got none expected %0d due cycle %0d (cycle %0d)",
               e.d0, e.due, cyc);
    end
    if (fd0) fd_seen0++;
    if (fd1) fd_seen1++;
    if (ov0) n_out0++;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      chk("out_valid", 64'(ov0), 64'sd1);
      chk("data_out", 64'(do0), 64'(e.d0));
      chk("frame_done", 64'(fd0), 64'(e.fd));
      chk("relu_out_valid", 64'(ov1), 64'sd1);
      chk("relu_data_out", 64'(do1), 64'(e.d1));
      chk("relu_frame_done", 64'(fd1), 64'(e.fd));
    end else begin
      chk("idle_out_valid", 64'(ov0), 64'sd0);
      chk("idle_data_out", 64'(do0), 64'sd0);
      chk("idle_frame_done", 64'(fd0), 64'sd0);
      chk("relu_idle_out_valid", 64'(ov1), 64'sd0);
      chk("relu_idle_data_out", 64'(do1), 64'sd0);
      chk("relu_idle_frame_done", 64'(fd1), 64'sd0);
    end
  end

  // Test sequence
  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 64'(ov0), 64'sd0);
    chk("reset_data_out", 64'(do0), 64'sd0);
    chk("reset_frame_done", 64'(fd0), 64'sd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Contiguous ramp: outputs 25, 27, ... 575
    send_frame(K_RAMP, 0, 1'b0, IW * IH);
    idle(3);

    // Same ramp with row gaps and random single-cycle gaps
    send_frame(K_RAMP, 0, 1'b1, IW * IH);
    idle(3);

    // Constant negative frame, then signed window, then single-peak frame
    send_frame(K_NEG5, 0, 1'b0, IW * IH);
    send_frame(K_WIN, 0, 1'b0, IW * IH);
    send_frame(K_POS, 0, 1'b1, IW * IH);
    idle(3);

    // Reset mid-frame after 100 samples, then a clean ramp frame
    send_frame(K_RAMP, 0, 1'b0, 100);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    idle(3);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_frame(K_RAMP, 0, 1'b0, IW * IH);

    // Back-to-back frames with no idle cycle between them
    send_frame(K_RAMP, 0, 1'b0, IW * IH);
    send_frame(K_RAMP, 10000, 1'b0, IW * IH);
    idle(5);

    chk("queue_drained", 64'(exp_q.size()), 64'sd0);
    chk("frame_done_count", 64'(fd_seen0), 64'(fd_exp));
    chk("relu_frame_done_count", 64'(fd_seen1), 64'(fd_exp));
    // 8 full frames of 144 plus 24 outputs from the interrupted frame
    chk("output_count", 64'(n_out0), 64'(8 * 144 + 24));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
